press_classify: RTL and testbench
=================================

# press_classify

Downstream consumer of the hysteresis glitch filter's debounced level `y`. It measures consecutive high and low run lengths of the filtered level and classifies each press as SHORT, LONG or DOUBLE. Each result is delivered as a one-entry valid/ready event to the control logic. A sticky overflow flag records events dropped because the consumer stalled.

## Interface
Parameters:
- `CW`, 8: width of run-length counter `cnt`. Requires LONG_T ≤ 2^CW−1 and DBL_T ≤ 2^CW−1.
- `LONG_T`, 100: high run length (in cycles) at which a press is LONG. Must be ≥ 2.
- `DBL_T`, 50: low gap length (in cycles) after a first release that closes the double-press window. Must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `i`  in  1  filtered level, driven from the glitch filter output `y`.
- `evt_valid`  out  1  event pending.
- `evt_code`  out  2  event code: 2'b01 SHORT, 2'b10 LONG, 2'b11 DOUBLE. Never 2'b00 while `evt_valid`=1.
- `evt_ready`  in  1  consumer accepts the event.
- `ovf`  out  1  sticky; an event was dropped.

## Operation
- Reset (`rst`=0 at a rising edge): state=IDLE, `cnt`=0, `evt_valid`=0, `evt_code`=2'b00, `ovf`=0. Reset has priority over all other logic, including a handshake in the same cycle.
- FSM states: IDLE, HIGH1, GAP, HIGH2, WAIT_REL. Encoding is free; an illegal state returns to IDLE.
- IDLE: i=1 → HIGH1, `cnt`=1.
- HIGH1: i=0 → GAP, `cnt`=1. Else if `cnt`==LONG_T−1 → emit LONG, go to WAIT_REL. Else `cnt`+1.
- GAP: i=1 → HIGH2. Else if `cnt`==DBL_T−1 → emit SHORT, go to IDLE. Else `cnt`+1.
- HIGH2: i=0 → emit DOUBLE, go to IDLE. No LONG detection on the second press.
- WAIT_REL: i=0 → IDLE. No event is emitted.
- `cnt` is only meaningful in HIGH1 and GAP. It never wraps, because the parameter constraints bound it.
- Event buffer, one entry:
  - Handshake completes when `evt_valid`=1 and `evt_ready`=1. `evt_valid` clears the next cycle unless a new event loads.
  - "Emit" loads `evt_code` and sets `evt_valid`=1 if the buffer is empty, or if it is being popped in the same cycle. In the pop-same-cycle case the new event replaces the old one, `evt_valid` stays 1, and `ovf` is not set.
  - Emit while `evt_valid`=1 and `evt_ready`=0: the new event is dropped, the held `evt_code` is unchanged, and `ovf` is set to 1.
  - `ovf` clears only on reset.
- `evt_valid` and `evt_code` stay stable while `evt_valid`=1 and `evt_ready`=0.
- `evt_ready` is ignored when `evt_valid`=0.
- If `i`=1 at the first edge after reset is released, this counts as a press start: IDLE → HIGH1.

## Timing
- Run length L = number of consecutive rising edges at which `i` is sampled at the same level.
- LONG: decided at the edge sampling the LONG_T-th consecutive high. `evt_valid` is visible in the following cycle, so latency is 1 cycle after the deciding sample.
- SHORT: the press has 1 ≤ L_high ≤ LONG_T−1. It is decided at the edge sampling the DBL_T-th consecutive low after release.
- DOUBLE: `i` rises within DBL_T−1 low samples of the first release. The event is decided at the edge sampling the first low after the second press.
- Edge cases:
  - A gap of exactly DBL_T−1 lows followed by a high gives DOUBLE.
  - A gap of DBL_T lows gives SHORT; a following high then starts a new press from IDLE.
  - A press of exactly LONG_T−1 highs is not LONG.
- Maximum event rate is one per cycle into the buffer; there is no internal queueing beyond one entry.

## Test plan
(CW=4, LONG_T=8, DBL_T=4; `evt_ready`=1 unless stated.)
- i=1 for 3 cycles, then 0 for ≥4 → SHORT (`evt_code`=01). `evt_valid`=1 for exactly 1 cycle, starting the cycle after the 4th low sample.
- i=1 for 20 cycles, then 0 for 10 → exactly one LONG (10), `evt_valid` rising 1 cycle after the 8th high. No event at release. Also: i=1 for 7 cycles → SHORT, not LONG.
- i=1 ×2, 0 ×3, 1 ×3, 0 ×6 → DOUBLE (11), `evt_valid` asserted the cycle after the first low following the second press. Repeat with a gap of 4 lows → two SHORT events.
- `evt_ready`=0; produce SHORT, then LONG → `evt_valid` held with `evt_code`=01 and `ovf`=1. Raise `evt_ready` → handshake, `evt_valid`=0; `ovf` stays 1.
- Hold SHORT pending, then assert `evt_ready`=1 in the same cycle a LONG is emitted → `evt_code`=10 next cycle, `evt_valid`=1, `ovf`=0.
- `rst`=0 for 1 cycle while in HIGH1 with `cnt`=5 and an event pending → next cycle all outputs 0. If `i` remains 1, a new LONG is reported only after 8 more highs counted from the release of reset.

Source files
------------

// File: rtl/press_classify.sv
// Press classifier: measures high/low run lengths of a debounced level and reports
// SHORT, LONG or DOUBLE presses through a one-entry valid/ready event buffer.
module press_classify #(
    parameter int CW     = 8,
    parameter int LONG_T = 100,
    parameter int DBL_T  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       ovf
);

    typedef enum logic [2:0] {
        IDLE,
        HIGH1,
        GAP,
        HIGH2,
        WAIT_REL
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_SHORT  = 2'b01,
        EV_LONG   = 2'b10,
        EV_DOUBLE = 2'b11
    } code_t;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_T - 1);
    localparam logic [CW-1:0] DBL_LAST  = CW'(DBL_T - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          emit;
    code_t         emit_code;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        emit_code = EV_NONE;
        case (state)
            IDLE: begin
                if (i) begin
                    state_nxt = HIGH1;
                    cnt_nxt   = ONE;
                end
            end
            HIGH1: begin
                if (!i) begin
                    state_nxt = GAP;
                    cnt_nxt   = ONE;
                end else if (cnt == LONG_LAST) begin
                    emit      = 1'b1;
                    emit_code = EV_LONG;
                    state_nxt = WAIT_REL;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            GAP: begin
                if (i) begin
                    state_nxt = HIGH2;
                end else if (cnt == DBL_LAST) begin
                    emit      = 1'b1;
                    emit_code = EV_SHORT;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            HIGH2: begin
                if (!i) begin
                    emit      = 1'b1;
                    emit_code = EV_DOUBLE;
                    state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (!i) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new event may replace the held one only when that one is popped in the same cycle;
    // otherwise it is dropped and the loss is remembered in ovf until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            evt_valid <= 1'b0;
            evt_code  <= EV_NONE;
            ovf       <= 1'b0;
        end else if (emit) begin
            if (!evt_valid || evt_ready) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code;
            end else begin
                ovf <= 1'b1;
            end
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_press_classify.sv
// Bench for press_classify: directed press scenarios followed by random level runs,
// all compared each cycle against a run-length reference model of the classifier.
module tb_press_classify;

    localparam int CW     = 4;
    localparam int LONG_T = 8;
    localparam int DBL_T  = 4;

    localparam logic [1:0] C_SHORT  = 2'b01;
    localparam logic [1:0] C_LONG   = 2'b10;
    localparam logic [1:0] C_DOUBLE = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       i;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: press state as run lengths and flags, buffer as valid/code/ovf.
    int         hi_run, lo_run;
    bit         p_press, p_gap, p_second, p_long;
    bit         m_valid, m_ovf;
    logic [1:0] m_code;

    press_classify #(.CW(CW), .LONG_T(LONG_T), .DBL_T(DBL_T)) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hi_run = 0; lo_run = 0;
        p_press = 0; p_gap = 0; p_second = 0; p_long = 0;
        m_valid = 0; m_ovf = 0; m_code = 2'b00;
    endtask

    // Classify one sampled level; returns whether an event is decided at this edge.
    task automatic model_sample(input bit s, output bit emit, output logic [1:0] code);
        emit = 0;
        code = 2'b00;
        if (s) begin
            hi_run++;
            lo_run = 0;
            if (p_gap) begin
                p_gap    = 0;
                p_second = 1;
            end else if (!p_long && !p_second) begin
                p_press = 1;
                if (hi_run == LONG_T) begin
                    emit = 1; code = C_LONG;
                    p_long = 1; p_press = 0;
                end
            end
        end else begin
            lo_run++;
            hi_run = 0;
            if (p_long) begin
                p_long = 0;
            end else if (p_second) begin
                emit = 1; code = C_DOUBLE;
                p_second = 0;
            end else if (p_press) begin
                p_press = 0;
                p_gap   = 1;
            end else if (p_gap && lo_run == DBL_T) begin
                emit = 1; code = C_SHORT;
                p_gap = 0;
            end
        end
    endtask

    task automatic model_edge(input bit iv, input bit rdy, input bit rs);
        bit         emit;
        logic [1:0] code;
        if (!rs) begin
            model_reset();
        end else begin
            model_sample(iv, emit, code);
            if (emit) begin
                if (!m_valid || rdy) begin
                    m_valid = 1;
                    m_code  = code;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare on the falling edge.
    task automatic cyc(input bit iv, input bit rdy, input bit rs);
        i         = iv;
        evt_ready = rdy;
        rst       = rs;
        @(posedge clk);
        model_edge(iv, rdy, rs);
        @(negedge clk);
        chk("valid", {1'b0, evt_valid}, {1'b0, m_valid});
        chk("ovf", {1'b0, ovf}, {1'b0, m_ovf});
        if (m_valid) chk("code", evt_code, m_code);
    endtask

    task automatic run(input bit iv, input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(iv, rdy, 1'b1);
    endtask

    initial begin
        rst = 1'b0; i = 1'b0; evt_ready = 1'b0;
        model_reset();
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_valid", {1'b0, evt_valid}, 2'b00);
        chk("rst_code", evt_code, 2'b00);
        chk("rst_ovf", {1'b0, ovf}, 2'b00);

        // SHORT: 3 highs then 4 lows; event for exactly one cycle.
        run(1, 3, 1);
        run(0, 3, 1);
        chk("short_early", {1'b0, evt_valid}, 2'b00);
        run(0, 1, 1);
        chk("short_valid", {1'b0, evt_valid}, 2'b01);
        chk("short_code", evt_code, C_SHORT);
        run(0, 1, 1);
        chk("short_pop", {1'b0, evt_valid}, 2'b00);

        // LONG on the 8th high; nothing at release.
        run(1, 7, 1);
        chk("long_early", {1'b0, evt_valid}, 2'b00);
        run(1, 1, 1);
        chk("long_valid", {1'b0, evt_valid}, 2'b01);
        chk("long_code", evt_code, C_LONG);
        run(1, 12, 1);
        run(0, 10, 1);
        chk("long_no_rel", {1'b0, evt_valid}, 2'b00);

        // 7 highs is SHORT, not LONG.
        run(1, 7, 1);
        run(0, 4, 1);
        chk("seven_code", evt_code, C_SHORT);
        chk("seven_valid", {1'b0, evt_valid}, 2'b01);
        run(0, 2, 1);

        // DOUBLE with a gap of DBL_T-1 lows.
        run(1, 2, 1);
        run(0, 3, 1);
        run(1, 3, 1);
        chk("dbl_early", {1'b0, evt_valid}, 2'b00);
        run(0, 1, 1);
        chk("dbl_valid", {1'b0, evt_valid}, 2'b01);
        chk("dbl_code", evt_code, C_DOUBLE);
        run(0, 5, 1);

        // Gap of DBL_T lows gives two SHORTs.
        run(1, 2, 1);
        run(0, 4, 1);
        chk("gap4_first", evt_code, C_SHORT);
        run(1, 3, 1);
        run(0, 4, 1);
        chk("gap4_second_v", {1'b0, evt_valid}, 2'b01);
        chk("gap4_second", evt_code, C_SHORT);
        run(0, 2, 1);

        // Stalled consumer: SHORT held, LONG dropped, ovf sticky across the pop.
        run(1, 3, 0);
        run(0, 4, 0);
        run(1, 8, 0);
        chk("ovf_hold_code", evt_code, C_SHORT);
        chk("ovf_set", {1'b0, ovf}, 2'b01);
        run(1, 1, 1);
        chk("ovf_pop", {1'b0, evt_valid}, 2'b00);
        chk("ovf_sticky", {1'b0, ovf}, 2'b01);
        run(0, 2, 1);
        cyc(0, 1, 0);
        chk("ovf_cleared", {1'b0, ovf}, 2'b00);

        // Pop and emit in the same cycle: LONG replaces SHORT without overflow.
        run(1, 3, 0);
        run(0, 4, 0);
        run(1, 7, 0);
        run(1, 1, 1);
        chk("replace_code", evt_code, C_LONG);
        chk("replace_valid", {1'b0, evt_valid}, 2'b01);
        chk("replace_ovf", {1'b0, ovf}, 2'b00);
        run(0, 2, 1);

        // Reset mid-press with an event pending; count restarts after release.
        run(1, 3, 0);
        run(0, 4, 0);
        run(1, 5, 0);
        cyc(1, 0, 0);
        chk("mid_rst_valid", {1'b0, evt_valid}, 2'b00);
        chk("mid_rst_code", evt_code, 2'b00);
        run(1, 7, 1);
        chk("mid_rst_early", {1'b0, evt_valid}, 2'b00);
        run(1, 1, 1);
        chk("mid_rst_long", evt_code, C_LONG);
        run(0, 3, 1);

        // Random level runs with a random consumer and occasional reset.
        for (int r = 0; r < 400; r++) begin
            int len;
            bit lvl;
            lvl = r[0];
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                cyc(lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
